// File: rtl/four_bit_adder_pkg.sv
// Shared constants for the registered 4-bit adder.
// Width and reset value of the sum register.
package four_bit_adder_pkg;
  localparam int ADDER_WIDTH = 4;
  localparam logic [ADDER_WIDTH-1:0] S_RST = '0;
endpackage

// File: rtl/four_bit_adder_full_adder.sv
// Single-bit full adder cell.
// One link of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder, one cycle latency.
// Sum/carry update only on in_valid; out_valid pulses per result.
module four_bit_adder
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= S_RST;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= s;
        Cout <= c[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder.
// Driver queues expected outputs; monitor pops and compares.
module tb_four_bit_adder;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       out_valid;

  typedef struct {
    logic       v;
    logic [4:0] r;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   m_sum;
  logic m_v;

  four_bit_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the held result is the exact integer A+B+Cin of the
  // last accepted operation, cleared by reset.
  task automatic apply(input logic r, input logic v,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input string nm);
    rst = r; in_valid = v; A = a; B = b; Cin = ci;
    @(posedge clk);
    if (r) begin
      m_v = 1'b0;
      m_sum = 0;
    end else begin
      m_v = v;
      if (v) m_sum = int'(a) + int'(b) + int'(ci);
    end
    q.push_back('{m_v, 5'(m_sum), nm});
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (out_valid !== e.v || {Cout, S} !== e.r) begin
        miscompares++;
        $display("FAIL %s: got v=%b {Cout,S}=%b, want v=%b {Cout,S}=%b",
                 e.nm, out_valid, {Cout, S}, e.v, e.r);
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
  } vec_t;

  vec_t dir[13];

  initial begin
    vectors = 0;
    miscompares = 0;
    m_sum = 0;
    m_v = 1'b0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    dir[0]  = '{4'b1010, 4'b0101, 1'b0};
    dir[1]  = '{4'b1101, 4'b1000, 1'b1};
    dir[2]  = '{4'b0100, 4'b1100, 1'b0};
    dir[3]  = '{4'b1111, 4'b1110, 1'b0};
    dir[4]  = '{4'b0010, 4'b1010, 1'b1};
    dir[5]  = '{4'b1111, 4'b0111, 1'b0};
    dir[6]  = '{4'b0110, 4'b1010, 1'b1};
    dir[7]  = '{4'b1101, 4'b1101, 1'b1};
    dir[8]  = '{4'b1000, 4'b0110, 1'b1};
    dir[9]  = '{4'b1010, 4'b1111, 1'b0};
    dir[10] = '{4'b1111, 4'b1111, 1'b1};
    dir[11] = '{4'b0000, 4'b0000, 1'b0};
    dir[12] = '{4'b1111, 4'b0000, 1'b1};

    for (int i = 0; i < 2; i++)
      apply(1'b1, 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), "reset");

    for (int i = 0; i < 13; i++) begin
      apply(1'b0, 1'b1, dir[i].a, dir[i].b, dir[i].ci, "directed");
      apply(1'b0, 1'b0, 4'($urandom), 4'($urandom),
            1'($urandom), "idle");
    end

    apply(1'b0, 1'b1, 4'b1001, 4'b0011, 1'b1, "hold_load");
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 4'($urandom), 4'($urandom),
            1'($urandom), "hold");

    apply(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, "pre_rst");
    apply(1'b1, 1'b1, 4'b0111, 4'b0101, 1'b1, "midstream_rst");
    apply(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, "post_rst_idle");
    apply(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0, "post_rst_first");

    for (int i = 0; i < 512; i++)
      apply(1'b0, 1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i), "exhaustive");

    for (int i = 0; i < 300; i++)
      apply(1'($urandom_range(0, 19) == 0), 1'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom), "random");

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
